// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: hazard/halt controller for a 5-stage pipeline (load-use stall, branch flush, halt/resume).
// Latency: control outputs are combinational (zero cycle); halted and counters are registered.
// Backpressure: halt freezes every stage register; load-use holds PC and IF/ID and injects one ID/EX bubble.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [4:0]       ex_req_w,
   input  logic             ex_w_en,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic             wb_halt,
   input  logic             resume,
   input  logic             cnt_clr,
   output logic             pc_en,
   output logic             pipe_en,
   output logic             if_id_stall,
   output logic             if_id_clr_n,
   output logic             id_ex_clr_n,
   output logic             ex_dm_clr_n,
   output logic             dm_wb_clr_n,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALT   = 2'd1,
      RESUME = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   state_t state_nxt;
   logic   load_use;
   logic   active;
   logic   stall_evt;
   logic   flush_evt;

   // A load in EX whose destination feeds a source the ID instruction really reads; $zero never hazards.
   assign load_use = ex_is_load & ex_w_en & (ex_req_w != 5'd0) &
                     ((id_rs_used & (id_rs == ex_req_w)) |
                      (id_rt_used & (id_rt == ex_req_w)));

   assign halted = (state == HALT);

   // State register; reset returns to RUN immediately from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // Next state and all stage controls; RESUME ignores the stale halt still sitting in DM/WB.
   always_comb begin
      state_nxt   = state;
      active      = 1'b0;
      pc_en       = 1'b0;
      pipe_en     = 1'b0;
      if_id_stall = 1'b0;
      if_id_clr_n = 1'b1;
      id_ex_clr_n = 1'b1;
      ex_dm_clr_n = 1'b1;
      dm_wb_clr_n = 1'b1;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
      if (!rst_n) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN: begin
               if (wb_halt) state_nxt = HALT;
               else         active    = 1'b1;
            end
            HALT: begin
               if (resume) state_nxt = RESUME;
            end
            RESUME: begin
               state_nxt = RUN;
               active    = 1'b1;
            end
            default: state_nxt = RUN;
         endcase
      end
      if (active) begin
         pipe_en = 1'b1;
         if (ex_branch_taken) begin
            // Taken branch squashes the wrong-path IF/ID and ID/EX contents; wins over load-use.
            pc_en       = 1'b1;
            if_id_clr_n = 1'b0;
            id_ex_clr_n = 1'b0;
            flush_evt   = 1'b1;
         end else if (load_use) begin
            if_id_stall = 1'b1;
            id_ex_clr_n = 1'b0;
            stall_evt   = 1'b1;
         end else begin
            pc_en = 1'b1;
         end
      end
   end

   // Saturating event counters; clear takes priority over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule
